// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared state encoding and beat counts for the SRAM controller
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int READ_BEATS  = 4;
  localparam int WRITE_BEATS = 2;

endpackage

// File: rtl/sram_beat_timer.sv
// rtl/sram_beat_timer.sv - per-beat cycle counter and beat index with terminal flags
module sram_beat_timer #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] last_idx,
  output logic [1:0] beat,
  output logic       beat_done,
  output logic       last_beat
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    beat_q, beat_d;

  assign beat      = beat_q;
  assign beat_done = run && (cnt_q == CNT_MAX);
  assign last_beat = (beat_q == last_idx);

  // Both counters fall back to zero whenever the FSM leaves an access state.
  always_comb begin
    cnt_d  = cnt_q;
    beat_d = beat_q;
    if (!run) begin
      cnt_d  = '0;
      beat_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      beat_d = beat_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      beat_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - cache-facing block read / word write controller for a 16-bit async SRAM
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int SRAM_AW       = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  input  logic               rd_en,
  input  logic               wr_en,
  output logic [63:0]        rdata,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  state_e               state_q, state_d;
  logic [SRAM_AW-1:0]   base_q, base_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [63:0]          rdata_q, rdata_d;
  logic                 dq_oe;
  logic [15:0]          dq_out;
  logic                 timer_run;
  logic [1:0]           last_idx;
  logic [1:0]           beat;
  logic                 beat_done;
  logic                 last_beat;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{address[31:SRAM_AW+1], address[0]};

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign rdata     = rdata_q;

  assign timer_run = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign last_idx  = (state_q == ST_READ) ? 2'(READ_BEATS - 1) : 2'(WRITE_BEATS - 1);

  sram_beat_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .run      (timer_run),
    .last_idx (last_idx),
    .beat     (beat),
    .beat_done(beat_done),
    .last_beat(last_beat)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready     = 1'b0;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    case (state_q)
      ST_IDLE: begin
        ready = !rd_en && !wr_en;
        // Write takes priority so a pending store is never overtaken by a refill.
        if (wr_en) begin
          state_d = ST_WRITE;
          base_d  = address[SRAM_AW:1];
          wdata_d = wdata;
        end else if (rd_en) begin
          state_d = ST_READ;
          base_d  = address[SRAM_AW:1];
        end
      end
      ST_READ: begin
        SRAM_ADDR = {base_q[SRAM_AW-1:2], beat};
        SRAM_OE_N = 1'b0;
        if (beat_done) begin
          rdata_d[{beat, 4'b0000} +: 16] = SRAM_DQ;
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        SRAM_ADDR = {base_q[SRAM_AW-1:1], beat[0]};
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = beat[0] ? wdata_q[31:16] : wdata_q[15:0];
        if (beat_done && last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with an async SRAM model
module tb_sram_controller;

  localparam int AC     = 2;
  localparam int RD_LAT = 4 * AC + 1;
  localparam int WR_LAT = 2 * AC + 1;

  typedef struct {
    logic        is_wr;
    logic [63:0] rdata;
    int          lat;
    int          we;
    logic [17:0] hw;
    logic [15:0] lo;
    logic [15:0] hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:(1<<18)-1];
  logic        pre_en = 1'b0;
  logic [17:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          low_cnt = 0;
  int          we_cnt = 0;
  logic        prev_ready = 1'b1;
  logic [63:0] last_rd = '0;

  always #5 clk = ~clk;

  sram_controller #(.SRAM_AW(18), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .rd_en(rd_en), .wr_en(wr_en), .rdata(rdata), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  assign sram_dq = sram_oe_n ? 16'hzzzz : mem[sram_addr];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q.delete();
      low_cnt    = 0;
      we_cnt     = 0;
      prev_ready = 1'b1;
    end else begin
      check("no_contention", {63'd0, (!sram_we_n && !sram_oe_n)}, 64'd0);
      if (!ready) low_cnt++;
      if (!sram_we_n) we_cnt++;
      if (ready && !prev_ready) begin
        if (q.size() == 0) begin
          check("unexpected_response", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check(e.is_wr ? "wr_latency" : "rd_latency", 64'(low_cnt), 64'(e.lat));
          check("we_low_cycles", 64'(we_cnt), 64'(e.we));
          check(e.is_wr ? "rdata_unchanged" : "rdata", rdata, e.rdata);
          if (e.is_wr) begin
            check("mem_lo", 64'(mem[e.hw]), 64'(e.lo));
            check("mem_hi", 64'(mem[e.hw + 18'd1]), 64'(e.hi));
          end
        end
        low_cnt = 0;
        we_cnt  = 0;
      end
      prev_ready = ready;
    end
  end

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic push_rd(input logic [63:0] d);
    exp_t e;
    e.is_wr = 1'b0; e.rdata = d; e.lat = RD_LAT; e.we = 0;
    e.hw = '0; e.lo = '0; e.hi = '0;
    q.push_back(e);
    last_rd = d;
  endtask

  task automatic push_wr(input logic [17:0] hw, input logic [31:0] d);
    exp_t e;
    e.is_wr = 1'b1; e.rdata = last_rd; e.lat = WR_LAT; e.we = 2 * AC;
    e.hw = hw; e.lo = d[15:0]; e.hi = d[31:16];
    q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, {63'd0, done}, 64'd1);
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input bit chg);
    address = a; wdata = d; rd_en = rd; wr_en = wr;
    #1;
    check("req_ready_low", {63'd0, ready}, 64'd0);
    if (chg) begin
      repeat (2) begin @(posedge clk); #1; end
      address = 32'h0003_0000;
      wdata   = 32'h1234_5678;
    end
    wait_done("access");
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_we_n", {63'd0, sram_we_n}, 64'd1);
    check("rst_oe_n", {63'd0, sram_oe_n}, 64'd1);
    check("rst_rdata", rdata, 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("tied_pins", {61'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 64'd0);

    preload(18'h100, 16'h1111); preload(18'h101, 16'h2222);
    preload(18'h102, 16'h3333); preload(18'h103, 16'h4444);
    preload(18'h104, 16'h5555); preload(18'h105, 16'h6666);
    preload(18'h106, 16'h7777); preload(18'h107, 16'h8888);
    preload(18'h18000, 16'h5A5A);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    push_rd(64'h4444_3333_2222_1111);
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);

    push_wr(18'h102, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 32'h204, 32'hDEAD_BEEF, 1'b0);

    push_rd(64'hDEAD_BEEF_2222_1111);
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 1'b1);

    push_wr(18'h106, 32'h0BAD_1234);
    do_access(1'b0, 1'b1, 32'h20C, 32'h0BAD_1234, 1'b1);
    check("latched_addr_only", 64'(mem[18'h18000]), 64'h5A5A);

    // Both requests together: write goes first, then the held read starts back-to-back.
    push_wr(18'h104, 32'hCAFE_F00D);
    push_rd(64'h0BAD_1234_CAFE_F00D);
    address = 32'h208; wdata = 32'hCAFE_F00D; rd_en = 1'b1; wr_en = 1'b1;
    @(posedge clk); #1;
    check("combo_write_first", {62'd0, sram_we_n, sram_oe_n}, 64'd1);
    wait_done("combo_wr");
    wr_en = 1'b0;
    @(posedge clk); #1;
    check("b2b_ready_low", {63'd0, ready}, 64'd0);
    wait_done("combo_rd");
    rd_en = 1'b0;
    @(posedge clk); #1;

    push_rd(64'hDEAD_BEEF_2222_1111);
    address = 32'h200; rd_en = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("mid_read_beat2_addr", 64'(sram_addr), 64'h102);
    rst = 1'b0; rd_en = 1'b0;
    #1;
    check("abort_we_n", {63'd0, sram_we_n}, 64'd1);
    check("abort_oe_n", {63'd0, sram_oe_n}, 64'd1);
    check("abort_rdata", rdata, 64'd0);
    check("abort_addr", 64'(sram_addr), 64'd0);
    check("abort_ready", {63'd0, ready}, 64'd1);
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b1;
    last_rd = '0;
    @(posedge clk); #1;

    push_rd(64'hDEAD_BEEF_2222_1111);
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
